// File: rtl/branch_fetch_redirect.sv
// branch_fetch_redirect: IF next-PC selection around the BTB plus ID-stage prediction check and redirect.
// Optional feature macro BRANCH_STATS_EN adds saturating branch_count / mispredict_count outputs.
`ifndef BTB_PREDICT_SIZE
`define BTB_PREDICT_SIZE 2
`endif
`ifndef STRONGLY_NOT_TAKEN
`define STRONGLY_NOT_TAKEN 2'b00
`endif
`ifndef WEAKLY_NOT_TAKEN
`define WEAKLY_NOT_TAKEN 2'b01
`endif
`ifndef WEAKLY_TAKEN
`define WEAKLY_TAKEN 2'b10
`endif
`ifndef STRONGLY_TAKEN
`define STRONGLY_TAKEN 2'b11
`endif

module branch_fetch_redirect #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         IF_hit,
    input  logic [`BTB_PREDICT_SIZE-1:0] taken,
    input  logic [DATA_WIDTH-1:0]        btb_branch_addr,
    input  logic                         ID_branch,
    input  logic                         ID_branch_taken,
    input  logic [DATA_WIDTH-1:0]        ID_branch_addr,
`ifdef BRANCH_STATS_EN
    output logic [31:0]                  branch_count,
    output logic [31:0]                  mispredict_count,
`endif
    output logic [DATA_WIDTH-1:0]        pc,
    output logic [DATA_WIDTH-1:0]        IF_predict_addr,
    output logic [DATA_WIDTH-1:0]        ID_branch_pc,
    output logic                         misprediction,
    output logic                         IF_flush
);
    logic                  pred_taken_now;
    logic [DATA_WIDTH-1:0] pred_next;
    logic [DATA_WIDTH-1:0] correct_pc;
    logic                  id_valid;
    logic                  id_pred_taken;
    logic [DATA_WIDTH-1:0] id_pred_target;

    // IF prediction from the BTB and ID check of the prediction carried from IF
    always_comb begin
        pred_taken_now  = IF_hit && (taken == `STRONGLY_TAKEN || taken == `WEAKLY_TAKEN);
        IF_predict_addr = pc + DATA_WIDTH'(4);
        pred_next       = pred_taken_now ? btb_branch_addr : IF_predict_addr;
        misprediction   = id_valid && ID_branch &&
                          ((id_pred_taken != ID_branch_taken) ||
                           (ID_branch_taken && id_pred_target != ID_branch_addr));
        correct_pc      = ID_branch_taken ? ID_branch_addr : ID_branch_pc + DATA_WIDTH'(4);
        IF_flush        = misprediction;
    end

    // Fetch PC and IF->ID record; a redirect wins over the IF prediction and bubbles ID
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc             <= RESET_PC;
            id_valid       <= 1'b0;
            id_pred_taken  <= 1'b0;
            id_pred_target <= '0;
            ID_branch_pc   <= '0;
        end else if (en) begin
            if (misprediction) begin
                pc       <= correct_pc;
                id_valid <= 1'b0;
            end else begin
                pc             <= pred_next;
                ID_branch_pc   <= pc;
                id_pred_taken  <= pred_taken_now;
                id_pred_target <= pred_next;
                id_valid       <= 1'b1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counts of resolved branches and mispredictions
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (en) begin
            if (id_valid && ID_branch && branch_count != '1)
                branch_count <= branch_count + 32'd1;
            if (misprediction && mispredict_count != '1)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_fetch_redirect.sv
// tb_branch_fetch_redirect: directed scenarios plus randomized run against an instruction-level reference model.
`ifndef WEAKLY_TAKEN
`define WEAKLY_TAKEN 2'b10
`endif
`ifndef STRONGLY_TAKEN
`define STRONGLY_TAKEN 2'b11
`endif

module tb_branch_fetch_redirect;
    logic        clk = 1'b0;
    logic        rst, en, IF_hit, ID_branch, ID_branch_taken;
    logic [1:0]  taken;
    logic [31:0] btb_branch_addr, ID_branch_addr;
    logic [31:0] pc, IF_predict_addr, ID_branch_pc;
    logic        misprediction, IF_flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count, mispredict_count;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_fetch_redirect dut (
        .clk(clk), .rst(rst), .en(en), .IF_hit(IF_hit), .taken(taken),
        .btb_branch_addr(btb_branch_addr), .ID_branch(ID_branch),
        .ID_branch_taken(ID_branch_taken), .ID_branch_addr(ID_branch_addr),
`ifdef BRANCH_STATS_EN
        .branch_count(branch_count), .mispredict_count(mispredict_count),
`endif
        .pc(pc), .IF_predict_addr(IF_predict_addr), .ID_branch_pc(ID_branch_pc),
        .misprediction(misprediction), .IF_flush(IF_flush)
    );

    // Reference model: the fetch PC and at most one predicted instruction sitting in ID
    typedef struct {logic pt; logic [31:0] tgt;} inst_t;
    inst_t       id_q[$];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_idpc = 32'h0;
    logic [31:0] m_bc = 32'h0;
    logic [31:0] m_mc = 32'h0;

    function automatic logic exp_mis();
        if (id_q.size() == 0 || !ID_branch) return 1'b0;
        if (id_q[0].pt != ID_branch_taken) return 1'b1;
        return ID_branch_taken && (id_q[0].tgt != ID_branch_addr);
    endfunction

    task automatic tick();
        logic mis, br, pt;
        logic [31:0] tgt, corr, cur;
        mis  = exp_mis();
        br   = id_q.size() != 0 && ID_branch;
        cur  = m_pc;
        pt   = IF_hit && (taken inside {`STRONGLY_TAKEN, `WEAKLY_TAKEN});
        tgt  = pt ? btb_branch_addr : cur + 32'd4;
        corr = ID_branch_taken ? ID_branch_addr : m_idpc + 32'd4;
        @(posedge clk);
        if (!rst) begin
            m_pc = 32'h0; m_idpc = 32'h0; id_q.delete(); m_bc = 0; m_mc = 0;
        end else if (en) begin
            if (br && m_bc != 32'hFFFFFFFF) m_bc++;
            if (mis && m_mc != 32'hFFFFFFFF) m_mc++;
            id_q.delete();
            if (mis) m_pc = corr;
            else begin
                id_q.push_back('{pt: pt, tgt: tgt});
                m_idpc = cur;
                m_pc = tgt;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b1; en = 1'b1; IF_hit = 1'b0; taken = 2'b00; btb_branch_addr = 32'h0;
        ID_branch = 1'b0; ID_branch_taken = 1'b0; ID_branch_addr = 32'h0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0; en = 1'b0; ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_branch_addr = 32'h55;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ID_branch_pc !== 32'h0) begin failures++; $display("FAIL reset_idpc got=%h exp=%h", ID_branch_pc, 32'h0); end
        checks++; if (misprediction !== 1'b0 || IF_flush !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b/%b exp=0/0", misprediction, IF_flush); end
        set_idle();
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i * 4);
            ID_branch = (i == 1); ID_branch_addr = 32'h999;
            #1;
            checks++; if (pc !== exp) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp); end
            checks++; if (misprediction !== 1'b0) begin failures++; $display("FAIL seq_mis%0d got=%b exp=0", i, misprediction); end
            if (i < 3) tick();
        end
        set_idle();
    endtask

    task automatic test_hit();
        do_reset();
        repeat (4) tick();
        checks++; if (pc !== 32'h10) begin failures++; $display("FAIL hit_start got=%h exp=%h", pc, 32'h10); end
        IF_hit = 1'b1; taken = `STRONGLY_TAKEN; btb_branch_addr = 32'h40;
        #1;
        checks++; if (IF_predict_addr !== 32'h14) begin failures++; $display("FAIL hit_pa got=%h exp=%h", IF_predict_addr, 32'h14); end
        tick();
        checks++; if (pc !== 32'h40) begin failures++; $display("FAIL hit_pc got=%h exp=%h", pc, 32'h40); end
        IF_hit = 1'b0; ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_branch_addr = 32'h40;
        #1;
        checks++; if (misprediction !== 1'b0) begin failures++; $display("FAIL hit_mis got=%b exp=0", misprediction); end
        checks++; if (ID_branch_pc !== 32'h10) begin failures++; $display("FAIL hit_idpc got=%h exp=%h", ID_branch_pc, 32'h10); end
        tick();
        checks++; if (pc !== 32'h44) begin failures++; $display("FAIL hit_next got=%h exp=%h", pc, 32'h44); end
        set_idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        IF_hit = 1'b1; taken = `STRONGLY_TAKEN; btb_branch_addr = 32'h20;
        tick();
        IF_hit = 1'b0;
        tick();
        checks++; if (pc !== 32'h24) begin failures++; $display("FAIL mp_start got=%h exp=%h", pc, 32'h24); end
        ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_branch_addr = 32'h80;
        #1;
        checks++; if (misprediction !== 1'b1 || IF_flush !== 1'b1) begin failures++; $display("FAIL mp_flag got=%b/%b exp=1/1", misprediction, IF_flush); end
        checks++; if (ID_branch_pc !== 32'h20) begin failures++; $display("FAIL mp_idpc got=%h exp=%h", ID_branch_pc, 32'h20); end
        tick();
        checks++; if (pc !== 32'h80) begin failures++; $display("FAIL mp_redirect got=%h exp=%h", pc, 32'h80); end
        checks++; if (misprediction !== 1'b0 || IF_flush !== 1'b0) begin failures++; $display("FAIL mp_bubble got=%b/%b exp=0/0", misprediction, IF_flush); end
        tick();
        checks++; if (pc !== 32'h84) begin failures++; $display("FAIL mp_after got=%h exp=%h", pc, 32'h84); end
        set_idle();
    endtask

    task automatic test_direction();
        do_reset();
        IF_hit = 1'b1; taken = `STRONGLY_TAKEN; btb_branch_addr = 32'h30;
        tick();
        btb_branch_addr = 32'h40;
        tick();
        IF_hit = 1'b0; ID_branch = 1'b1; ID_branch_taken = 1'b0; ID_branch_addr = 32'h0;
        #1;
        checks++; if (misprediction !== 1'b1) begin failures++; $display("FAIL dir_nt_mis got=%b exp=1", misprediction); end
        tick();
        checks++; if (pc !== 32'h34) begin failures++; $display("FAIL dir_nt_pc got=%h exp=%h", pc, 32'h34); end
        ID_branch = 1'b0; IF_hit = 1'b1; taken = `WEAKLY_TAKEN; btb_branch_addr = 32'h40;
        tick();
        IF_hit = 1'b0; ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_branch_addr = 32'h50;
        #1;
        checks++; if (misprediction !== 1'b1) begin failures++; $display("FAIL dir_tgt_mis got=%b exp=1", misprediction); end
        tick();
        checks++; if (pc !== 32'h50) begin failures++; $display("FAIL dir_tgt_pc got=%h exp=%h", pc, 32'h50); end
        set_idle();
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        ID_branch = 1'b1; ID_branch_taken = 1'b1; ID_branch_addr = 32'h100; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc !== 32'h4 || misprediction !== 1'b1) begin failures++; $display("FAIL stall%0d got pc=%h mis=%b exp pc=%h mis=1", i, pc, misprediction, 32'h4); end
            tick();
        end
        en = 1'b1;
        tick();
        checks++; if (pc !== 32'h100 || misprediction !== 1'b0) begin failures++; $display("FAIL stall_apply got pc=%h mis=%b exp pc=%h mis=0", pc, misprediction, 32'h100); end
        ID_branch = 1'b0;
        tick();
        ID_branch = 1'b1; ID_branch_addr = 32'h200;
        #1;
        checks++; if (misprediction !== 1'b1) begin failures++; $display("FAIL stall_pend got=%b exp=1", misprediction); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || misprediction !== 1'b0) begin failures++; $display("FAIL stall_rst got pc=%h mis=%b exp pc=0 mis=0", pc, misprediction); end
        set_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        IF_hit = 1'b1; taken = `STRONGLY_TAKEN; btb_branch_addr = 32'hFFFFFFFC;
        tick();
        IF_hit = 1'b0;
        #1;
        checks++; if (pc !== 32'hFFFFFFFC || IF_predict_addr !== 32'h0) begin failures++; $display("FAIL wrap_pa got pc=%h pa=%h exp pc=fffffffc pa=0", pc, IF_predict_addr); end
        tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        set_idle();
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            en = ($urandom_range(0, 4) != 0);
            IF_hit = 1'($urandom_range(0, 1));
            taken = 2'($urandom_range(0, 3));
            r = $urandom;
            btb_branch_addr = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : (r & 32'hFFFFFFFC);
            ID_branch = 1'($urandom_range(0, 1));
            if (id_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                ID_branch_taken = id_q[0].pt;
                ID_branch_addr = id_q[0].tgt;
            end else begin
                ID_branch_taken = 1'($urandom_range(0, 1));
                r = $urandom;
                ID_branch_addr = r & 32'hFFFFFFFC;
            end
            #1;
            checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc it=%0d got=%h exp=%h", i, pc, m_pc); end
            checks++; if (IF_predict_addr !== m_pc + 32'd4) begin failures++; $display("FAIL rnd_pa it=%0d got=%h exp=%h", i, IF_predict_addr, m_pc + 32'd4); end
            checks++; if (ID_branch_pc !== m_idpc) begin failures++; $display("FAIL rnd_idpc it=%0d got=%h exp=%h", i, ID_branch_pc, m_idpc); end
            checks++; if (misprediction !== exp_mis() || IF_flush !== exp_mis()) begin failures++; $display("FAIL rnd_mis it=%0d got=%b/%b exp=%b", i, misprediction, IF_flush, exp_mis()); end
`ifdef BRANCH_STATS_EN
            checks++; if (branch_count !== m_bc || mispredict_count !== m_mc) begin failures++; $display("FAIL rnd_stats it=%0d got=%0d/%0d exp=%0d/%0d", i, branch_count, mispredict_count, m_bc, m_mc); end
`endif
            tick();
        end
        set_idle();
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin failures++; $display("FAIL st_reset got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
        tick();
        ID_branch = 1'b1; ID_branch_taken = 1'b0;
        repeat (3) tick();
        ID_branch_taken = 1'b1; ID_branch_addr = 32'h300;
        tick();
        checks++; if (branch_count !== 32'd4 || mispredict_count !== 32'd1) begin failures++; $display("FAIL st_counts got=%0d/%0d exp=4/1", branch_count, mispredict_count); end
        ID_branch = 1'b0;
        tick();
        force dut.branch_count = 32'hFFFFFFFF;
        #1;
        release dut.branch_count;
        m_bc = 32'hFFFFFFFF;
        ID_branch = 1'b1; ID_branch_taken = 1'b0;
        tick();
        checks++; if (branch_count !== 32'hFFFFFFFF) begin failures++; $display("FAIL st_sat got=%h exp=ffffffff", branch_count); end
        set_idle();
    endtask
`endif

    initial begin
        set_idle();
        test_reset();
        test_sequential();
        test_hit();
        test_mispredict();
        test_direction();
        test_stall();
        test_wrap();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
